// File: rtl/enc_8to3_serializer.sv
// enc_8to3_serializer: walks a multi-hot request vector and emits the index
// of every set bit as a binary code, lowest index first, one per handshake.
//
// Optional feature macro: ENC_MERGE_EN
//   undefined (default): a new vector is only taken while idle; in_rdy=0
//                        while indices are being issued.
//   defined:             in_rdy is tied high and vectors arriving while
//                        issuing are ORed into the pending mask.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. A source holds its payload stable
// while valid is high and ready is low; out_idx/out_last/pending never
// change during an output stall (except merged bits, see ENC_MERGE_EN).
//
// The FSM state is directly visible on out_vld (ISSUE <=> out_vld=1).
module enc_8to3_serializer #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_vec,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             out_last,
    output logic [N-1:0]     pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             accept;
    logic             pop;
    logic             select;
    logic [N-1:0]     cleared;

    // Index of the lowest set bit (bit 0 has highest priority).
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
        lowest_set = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic single_bit(input logic [N-1:0] v);
        single_bit = (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

`ifdef ENC_MERGE_EN
    assign in_rdy = 1'b1;
`else
    assign in_rdy = (state_q == IDLE);
`endif

    assign accept   = in_vld && in_rdy;
    assign pop      = out_vld && out_rdy;
    assign out_vld  = (state_q == ISSUE);
    assign out_idx  = idx_q;
    assign out_last = last_q;
    assign pending  = pending_q;

    // Next pending mask, next index selection and next state.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        pending_d = pending_q;
        select    = 1'b0;
        cleared   = pending_q;

        // Popping clears the issued bit; a same-cycle merged copy of that
        // bit is ORed back afterwards, so set wins. Without merging, an
        // accept only happens while idle, where pending is already zero.
        if (pop) cleared = pending_q & ~(N'(1) << idx_q);
        pending_d = cleared | (accept ? in_vec : '0);

        // A fresh index is chosen only after a pop or when leaving idle;
        // during a stall the held index is never preempted.
        select = pop || (state_q == IDLE);
        if (select && (pending_d != '0)) idx_d = lowest_set(pending_d);

        last_d  = single_bit(pending_d);
        state_d = (pending_d != '0) ? ISSUE : IDLE;
    end

    // State and output registers; reset discards any pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_enc_8to3_serializer.sv
// Directed bench for enc_8to3_serializer with an expected-index scoreboard.
module tb_enc_8to3_serializer;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     in_vec;
    logic             in_vld;
    logic             in_rdy;
    logic [IDX_W-1:0] out_idx;
    logic             out_vld;
    logic             out_rdy;
    logic             out_last;
    logic [N-1:0]     pending;

    // Scoreboard entries are {last, idx}.
    logic [IDX_W:0] exp_q[$];
    int tests_run;
    int tests_failed;

    enc_8to3_serializer #(.N(N), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vec   (in_vec),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_idx  (out_idx),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .pending  (pending)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input bit last);
        exp_q.push_back({last, IDX_W'(idx)});
    endtask

    // Called at a falling edge with inputs already applied: scores a pop
    // that will occur at the next rising edge, then advances one cycle.
    task automatic cycle();
        logic [IDX_W:0] e;
        if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {28'd0, out_last, out_idx}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pop_idx", 32'(out_idx), 32'(e[IDX_W-1:0]));
                check("pop_last", 32'(out_last), 32'(e[IDX_W]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one vector for exactly one cycle.
    task automatic drive_vec(input logic [N-1:0] v);
        in_vec = v;
        in_vld = 1'b1;
        cycle();
        in_vld = 1'b0;
        in_vec = '0;
    endtask

    // Run until the scoreboard empties, bounded by a cycle budget.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pending"}, 32'(pending), 32'd0);
        check({tag, "_out_vld"}, 32'(out_vld), 32'd0);
        check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        in_vec  = '0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;

        // Reset
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst_hold");
        rst_n = 1'b1;
        cycle();
        check_reset_vals("rst_release");

        // Basic serialization: 1010_0100 -> 2, 5, 7(last)
        out_rdy = 1'b1;
        push_exp(2, 0);
        push_exp(5, 0);
        push_exp(7, 1);
        drive_vec(8'b1010_0100);
        check("basic_vld_latency", 32'(out_vld), 32'd1);
        check("basic_pending", 32'(pending), 32'hA4);
        drain(10);
        check("basic_idle_vld", 32'(out_vld), 32'd0);
        check("basic_idle_rdy", 32'(in_rdy), 32'd1);
        check("basic_idx_kept", 32'(out_idx), 32'd7);
        check("basic_idle_last", 32'(out_last), 32'd0);

        // Backpressure: 0000_0011 stalled four cycles
        out_rdy = 1'b0;
        push_exp(0, 0);
        push_exp(1, 1);
        drive_vec(8'b0000_0011);
        for (int i = 0; i < 4; i++) begin
            check("bp_vld", 32'(out_vld), 32'd1);
            check("bp_idx", 32'(out_idx), 32'd0);
            check("bp_last", 32'(out_last), 32'd0);
            check("bp_pending", 32'(pending), 32'h03);
            cycle();
        end
        out_rdy = 1'b1;
        drain(10);
        check("bp_idle_vld", 32'(out_vld), 32'd0);

        // Zero vector is accepted and dropped
        check("zero_rdy_before", 32'(in_rdy), 32'd1);
        drive_vec('0);
        check("zero_no_vld", 32'(out_vld), 32'd0);
        check("zero_rdy_after", 32'(in_rdy), 32'd1);
        check("zero_pending", 32'(pending), 32'd0);

`ifdef ENC_MERGE_EN
        // Merge: 1000_0010 stalled at idx 1; merge 01 during stall, then
        // merge 03 on the popping cycle -> 1, 0, 1, 7(last)
        out_rdy = 1'b0;
        drive_vec(8'b1000_0010);
        check("mg_first_idx", 32'(out_idx), 32'd1);
        drive_vec(8'b0000_0001);
        check("mg_held_idx", 32'(out_idx), 32'd1);
        check("mg_pending", 32'(pending), 32'h83);
        check("mg_last", 32'(out_last), 32'd0);
        push_exp(1, 0);
        out_rdy = 1'b1;
        drive_vec(8'b0000_0011);
        check("mg_set_wins", 32'(pending), 32'h83);
        push_exp(0, 0);
        push_exp(1, 0);
        push_exp(7, 1);
        drain(10);
        check("mg_idle_vld", 32'(out_vld), 32'd0);
`else
        // All-ones vector with an ignored in_vld while busy -> exactly 0..7
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) push_exp(i, i == N - 1);
        drive_vec(8'hFF);
        in_vec = 8'h01;
        in_vld = 1'b1;
        check("blk_rdy_low", 32'(in_rdy), 32'd0);
        cycle();
        cycle();
        in_vld = 1'b0;
        in_vec = '0;
        drain(12);
        for (int i = 0; i < 3; i++) begin
            check("blk_no_stale", 32'(out_vld), 32'd0);
            cycle();
        end
`endif

        // Reset mid-operation while issuing idx 3 of F8
        out_rdy = 1'b0;
        drive_vec(8'hF8);
        check("mid_idx3", 32'(out_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_async");
        exp_q.delete();
        @(negedge clk);
        out_rdy = 1'b1;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("mid_after_rdy", 32'(in_rdy), 32'd1);
            check("mid_after_vld", 32'(out_vld), 32'd0);
            cycle();
        end
        check("mid_after_idx", 32'(out_idx), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
